// File: rtl/rs_gf_pkg.sv
// Shared GF(2^5) definitions for the RS decoder: field constants, helpers and the response record.
package rs_gf_pkg;

    localparam int GF_M = 5;
    localparam logic [GF_M:0] GF_POLY = 6'b100101;
    localparam int MAX_IDW = 3;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
        logic [GF_M-1:0]    data;
    } rsp_t;

    function automatic int idw_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Shift-and-add multiply; the x^5 overflow folds back as x^2 + 1.
    function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
        logic [GF_M-1:0] p;
        logic [GF_M-1:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < GF_M; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = t[GF_M-1] ? ({t[GF_M-2:0], 1'b0} ^ GF_POLY[GF_M-1:0]) : {t[GF_M-2:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_mult_scheduler_muladd.sv
// Combinational GF(2^5) multiply-add y = a*b xor c.
module gf_muladd
    import rs_gf_pkg::*;
(
    input  logic [GF_M-1:0] a_i,
    input  logic [GF_M-1:0] b_i,
    input  logic [GF_M-1:0] c_i,
    output logic [GF_M-1:0] y_o
);

    logic [GF_M-1:0] product;

    assign product = gf_mul(a_i, b_i);
    assign y_o     = product ^ c_i;

endmodule

// File: rtl/gf_mult_scheduler.sv
// Round-robin scheduler time-sharing one GF(2^5) multiply-add among NREQ requesters,
// with per-requester burst locking and a single registered response slot.
module gf_mult_scheduler
    import rs_gf_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [GF_M*NREQ-1:0] req_a,
    input  logic [GF_M*NREQ-1:0] req_b,
    input  logic [GF_M*NREQ-1:0] req_c,
    input  logic [NREQ-1:0]      req_lock,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [GF_M-1:0]      rsp_data,
    output logic                 locked
);

    lock_state_e     state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    rsp_t            rsp_q, rsp_d;

    logic            issueOk;
    logic            winFound;
    logic [IDW-1:0]  winIdx;
    int unsigned     cand;
    logic [IDW-1:0]  grantIdx;
    logic            grantValid;
    logic            accept;
    logic            acceptLock;
    logic [GF_M-1:0] opA, opB, opC, result;

    function automatic logic [IDW-1:0] nextIdx(input logic [IDW-1:0] w);
        return (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
    endfunction

    assign issueOk = !rsp_q.valid || rsp_ready;

    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        cand     = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!winFound && req_valid[cand]) begin
                winFound = 1'b1;
                winIdx   = IDW'(cand);
            end
        end
    end

    // A held lock overrides the round-robin search entirely, even if the owner is idle.
    assign grantIdx   = (state_q == LOCKED) ? owner_q : winIdx;
    assign grantValid = (state_q == LOCKED) ? req_valid[owner_q] : winFound;

    always_comb begin
        req_ready = '0;
        if (reset_n && issueOk && grantValid) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign accept     = |req_ready;
    assign acceptLock = req_lock[grantIdx];

    assign opA = req_a[int'(grantIdx)*GF_M +: GF_M];
    assign opB = req_b[int'(grantIdx)*GF_M +: GF_M];
    assign opC = req_c[int'(grantIdx)*GF_M +: GF_M];

    gf_muladd u_muladd (
        .a_i (opA),
        .b_i (opB),
        .c_i (opC),
        .y_o (result)
    );

    always_comb begin
        rsp_d = rsp_q;
        if (accept) begin
            rsp_d.valid = 1'b1;
            rsp_d.id    = MAX_IDW'(grantIdx);
            rsp_d.data  = result;
        end else if (rsp_ready) begin
            rsp_d.valid = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && (state_q == UNLOCKED)) begin
            ptr_d = nextIdx(grantIdx);
        end else if (accept && !acceptLock) begin
            ptr_d = nextIdx(owner_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
            ptr_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            UNLOCKED: begin
                if (accept && acceptLock) begin
                    state_d = LOCKED;
                    owner_d = grantIdx;
                end
            end
            LOCKED: begin
                if (accept && !acceptLock) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_id    = IDW'(rsp_q.id);
    assign rsp_data  = rsp_q.data;

endmodule

// File: tb/tb_gf_mult_scheduler.sv
// Scoreboard bench for gf_mult_scheduler: expected responses are queued per scenario and
// popped as the DUT hands results downstream.
module tb_gf_mult_scheduler;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef struct {
      logic [1:0] id;
      logic [4:0] data;
   } expT;

   logic              clock;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [5*NREQ-1:0] req_a;
   logic [5*NREQ-1:0] req_b;
   logic [5*NREQ-1:0] req_c;
   logic [NREQ-1:0]   req_lock;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [4:0]        rsp_data;
   logic              locked;

   expT         expQ[$];
   logic [4:0]  opA [NREQ];
   logic [4:0]  opB [NREQ];
   logic [4:0]  opC [NREQ];
   int          remaining [NREQ];
   int          xferIdx [NREQ];
   logic [7:0]  lockPat [NREQ];
   logic [3:0]  lastAccepted;
   logic        expLk;
   int          lockOwner;
   bit          checkLock;
   int          lockedCycles;
   int          stepCount;
   int          fireCount;
   int          firstFire;
   int          lastFire;
   int          assertCount;
   int          failCount;

   gf_mult_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_lock  (req_lock),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .locked    (locked)
   );

   // Free-running 10-time-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference multiply-add: full carry-less product, then reduce from the top bit down.
   function automatic logic [4:0] refMulAdd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      logic [8:0] p;
      logic [8:0] poly;
      p = '0;
      poly = 9'b000100101;
      for (int i = 0; i < 5; i++)
         if (b[i]) p = p ^ (9'(a) << i);
      for (int k = 8; k >= 5; k--)
         if (p[k]) p = p ^ (poly << (k - 5));
      return p[4:0] ^ c;
   endfunction

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Loads a requester's operands, transfer count and per-transfer lock bits.
   task automatic applyStimulus(input int i, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                input int count, input logic [7:0] lockBits);
      opA[i] = a;
      opB[i] = b;
      opC[i] = c;
      req_a[i*5 +: 5] = a;
      req_b[i*5 +: 5] = b;
      req_c[i*5 +: 5] = c;
      remaining[i] = count;
      xferIdx[i] = 0;
      lockPat[i] = lockBits;
   endtask

   task automatic pushExp(input int i);
      expT e;
      e.id = 2'(i);
      e.data = refMulAdd(opA[i], opB[i], opC[i]);
      expQ.push_back(e);
   endtask

   task automatic driveInputs();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = remaining[i] > 0;
         req_lock[i] = (remaining[i] > 0) ? lockPat[i][xferIdx[i]] : 1'b0;
      end
   endtask

   // One clock: drive, sample at the falling edge, account for handshakes, move past the rising edge.
   task automatic step();
      expT e;
      driveInputs();
      @(negedge clock);
      stepCount++;
      checkOutput("oneHotReady", 32'($countones(req_ready) <= 1), 32'd1);
      if (checkLock) begin
         checkOutput("lockedFlag", 32'(locked), 32'(expLk));
         if (expLk)
            checkOutput("lockExclusive", 32'(req_ready & ~(4'b0001 << lockOwner)), 32'd0);
      end
      if (locked) lockedCycles++;
      if (rsp_valid && rsp_ready) begin
         if (firstFire < 0) firstFire = stepCount;
         lastFire = stepCount;
         fireCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpectedRsp", 32'(rsp_id), 32'hFFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("rspId", 32'(rsp_id), 32'(e.id));
            checkOutput("rspData", 32'(rsp_data), 32'(e.data));
         end
      end
      lastAccepted = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (lastAccepted[i]) begin
            if (!expLk && req_lock[i]) begin
               expLk = 1'b1;
               lockOwner = i;
            end else if (expLk && !req_lock[i]) begin
               expLk = 1'b0;
            end
            remaining[i]--;
            xferIdx[i]++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic runUntilDrained(input int maxCycles);
      int n;
      bit pending;
      n = 0;
      pending = 1'b1;
      while (pending && n < maxCycles) begin
         pending = expQ.size() > 0;
         for (int i = 0; i < NREQ; i++)
            if (remaining[i] > 0) pending = 1'b1;
         if (pending) begin
            step();
            n++;
         end
      end
      checkOutput("drainLeft", 32'(expQ.size()), 32'd0);
   endtask

   task automatic clearTracking();
      fireCount = 0;
      firstFire = -1;
      lastFire = -1;
      lockedCycles = 0;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 0;
         xferIdx[i] = 0;
         lockPat[i] = '0;
      end
      req_valid = '0;
      req_lock = '0;
      rsp_ready = 1'b1;
      expQ.delete();
      expLk = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      clearTracking();
   endtask

   initial begin
      assertCount = 0;
      failCount = 0;
      stepCount = 0;
      checkLock = 1'b0;
      expLk = 1'b0;
      lockOwner = 0;
      lastAccepted = '0;
      clearTracking();
      reset_n = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '1;
      req_lock = '0;
      req_a = '0;
      req_b = '0;
      req_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 0;
         xferIdx[i] = 0;
         lockPat[i] = '0;
      end

      #12;
      $display("[TB] reset values");
      checkOutput("rstValid", 32'(rsp_valid), 32'd0);
      checkOutput("rstId", 32'(rsp_id), 32'd0);
      checkOutput("rstData", 32'(rsp_data), 32'd0);
      checkOutput("rstLocked", 32'(locked), 32'd0);
      checkOutput("rstReady", 32'(req_ready), 32'd0);
      doReset();

      $display("[TB] basic product and reduction");
      applyStimulus(0, 5'b00010, 5'b00010, 5'b00000, 1, 8'h00);
      pushExp(0);
      step();
      checkOutput("basicAccept", 32'(lastAccepted), 32'b0001);
      checkOutput("basicLatency", 32'(rsp_valid), 32'd1);
      checkOutput("basicData", 32'(rsp_data), 32'b00100);
      runUntilDrained(10);
      applyStimulus(0, 5'b10000, 5'b00010, 5'b00011, 1, 8'h00);
      pushExp(0);
      step();
      checkOutput("reduceData", 32'(rsp_data), 32'b00110);
      runUntilDrained(10);

      $display("[TB] round-robin fairness");
      doReset();
      for (int i = 0; i < NREQ; i++)
         applyStimulus(i, 5'(3 + i*7), 5'(9 + i*5), 5'(i*11), (i < 2) ? 2 : 1, 8'h00);
      pushExp(0); pushExp(1); pushExp(2); pushExp(3); pushExp(0); pushExp(1);
      runUntilDrained(30);
      checkOutput("fairCount", 32'(fireCount), 32'd6);
      checkOutput("fairBackToBack", 32'(lastFire - firstFire), 32'd5);

      $display("[TB] back-pressure");
      doReset();
      rsp_ready = 1'b0;
      applyStimulus(1, 5'b10101, 5'b01101, 5'b00111, 1, 8'h00);
      applyStimulus(2, 5'b11111, 5'b11011, 5'b10000, 1, 8'h00);
      pushExp(1); pushExp(2);
      step();
      for (int s = 0; s < 3; s++) begin
         checkOutput("stallReady", 32'(req_ready), 32'd0);
         checkOutput("stallValid", 32'(rsp_valid), 32'd1);
         checkOutput("stallId", 32'(rsp_id), 32'd1);
         checkOutput("stallData", 32'(rsp_data), 32'(refMulAdd(5'b10101, 5'b01101, 5'b00111)));
         step();
      end
      rsp_ready = 1'b1;
      runUntilDrained(20);

      $display("[TB] lock burst");
      doReset();
      applyStimulus(1, 5'b00001, 5'b00111, 5'b00000, 1, 8'h00);
      pushExp(1);
      runUntilDrained(10);
      clearTracking();
      applyStimulus(0, 5'b01010, 5'b00110, 5'b00001, 1, 8'h00);
      applyStimulus(2, 5'b11001, 5'b00101, 5'b01110, 3, 8'b011);
      applyStimulus(3, 5'b00111, 5'b11100, 5'b10010, 1, 8'h00);
      pushExp(2); pushExp(2); pushExp(2); pushExp(3); pushExp(0);
      checkLock = 1'b1;
      runUntilDrained(30);
      checkLock = 1'b0;
      checkOutput("lockedCycles", 32'(lockedCycles), 32'd2);

      $display("[TB] reset while locked");
      doReset();
      rsp_ready = 1'b0;
      applyStimulus(1, 5'b01011, 5'b01011, 5'b00000, 1, 8'h01);
      applyStimulus(3, 5'b10011, 5'b00110, 5'b11000, 1, 8'h00);
      step();
      checkOutput("midLockLocked", 32'(locked), 32'd1);
      checkOutput("midLockValid", 32'(rsp_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midRstValid", 32'(rsp_valid), 32'd0);
      checkOutput("midRstLocked", 32'(locked), 32'd0);
      checkOutput("midRstReady", 32'(req_ready), 32'd0);
      expLk = 1'b0;
      rsp_ready = 1'b1;
      applyStimulus(0, 5'b00110, 5'b01001, 5'b00101, 1, 8'h00);
      driveInputs();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      pushExp(0); pushExp(3);
      runUntilDrained(20);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Hard time limit so a stuck handshake can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/gf_mult_scheduler.md
# gf_mult_scheduler

Round-robin scheduler that shares one GF(2^5) multiply-add datapath (product a·b ⊕ c, field polynomial x^5 + x^2 + 1) among NREQ requesters. It sits between the syndrome, key-equation and Chien/Forney stages of the RS decoder, so a single multiplier can be time-shared instead of replicated. Each request is accepted through a valid/ready handshake, optionally locked for back-to-back bursts, and returned one cycle later with its requester ID.

## Interface
- NREQ, default 4: number of requesters, allowed range 2–8.
- IDW, default 2: ID width; must equal ceil(log2(NREQ)).

Ports:
- clock  in  1  rising-edge clock; the design has this one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit is set per cycle.
- req_a  in  5*NREQ  operand a; requester i uses bits [5i+4:5i]; bit 4 is the x^4 coefficient.
- req_b  in  5*NREQ  operand b; same packing as req_a.
- req_c  in  5*NREQ  addend c; same packing.
- req_lock  in  NREQ  keeps the grant with this requester after the current transfer.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  5  a·b ⊕ c.
- locked  out  1  a lock is held.

## Operation
- **Datapath.** The result is prod(a,b) XOR c, where prod is the combinational polynomial-basis GF(2^5) product.
- **Capacity.** There is one output register. It holds rsp_valid, rsp_id and rsp_data.
- **Issue condition.** `issue_ok = !rsp_valid | rsp_ready`. No request is accepted when issue_ok is 0.
- **Arbitration.** The pointer `ptr` gives the highest-priority index. The search order is ptr, ptr+1, …, wrapping modulo NREQ. The winner is the first index with req_valid set.
- **Accept.** `req_ready[w]` = issue_ok and no lock held, or issue_ok and a lock held by w. It is purely combinational; no other ready bit is set.
- **On accept of winner w:**
  - the output register loads the result;
  - rsp_id becomes w;
  - rsp_valid becomes 1;
  - ptr becomes (w+1) mod NREQ.
- **Lock FSM.**
  - States: UNLOCKED and LOCKED(owner).
  - UNLOCKED to LOCKED(w): on an accepted transfer with req_lock[w]=1.
  - LOCKED(w) to UNLOCKED: on an accepted transfer from w with req_lock[w]=0.
  - While LOCKED(w), other requesters get no ready, even if w is idle.
  - While LOCKED, ptr is unchanged; on unlock it becomes (w+1) mod NREQ.
- **Drain without refill.** If rsp_valid and rsp_ready are 1 and no request is accepted, rsp_valid clears.
- **Output stability.** rsp_data and rsp_id must not change while rsp_valid=1 and rsp_ready=0.
- **Input stability.** Requesters keep their inputs stable until ready. The scheduler does not latch operands that were not accepted.

## Timing
- **Latency.** An accept in cycle N gives rsp_valid=1 with the result in cycle N+1.
- **Throughput.** One result per cycle while rsp_ready stays 1.
- **Back-pressure.** With rsp_valid=1 and rsp_ready=0, all req_ready are 0 in the same cycle.
- **Reset values** (asynchronous assert; deassertion sampled on clock):
  - rsp_valid=0, rsp_id=0, rsp_data=0;
  - ptr=0, state UNLOCKED, locked=0;
  - req_ready=0 while reset_n=0.
- **Reset mid-operation.** A pending result and any held lock are discarded. No response is emitted for that transfer.
- **Simultaneous events.**
  - Drain and accept in the same cycle: the register loads the new result; rsp_valid stays 1.
  - Unlock and new lock by the same owner in one transfer: not possible, because one req_lock bit is sampled per transfer.
- **Wrap-around.** From ptr=NREQ-1, the next pointer after a winner at NREQ-1 is 0.

## Structure
Shared package rs_gf_pkg holds:
- constant GF_M=5;
- constant field polynomial 6'b100101;
- IDW calculation helper;
- rsp record type (valid, id, data).

Sub-modules:
- The multiply-add is a sub-module gf_muladd, built from the existing multiplier and adder modules. It is combinational.
- The arbiter pointer and lock FSM stay in gf_mult_scheduler. Expected size is about 200 lines.

## Test plan
- **Reset and basic product.** Hold reset_n low, then release. Requester 0 sends a=00010, b=00010, c=00000. Expect rsp_data=00100 and rsp_id=0 one cycle after accept.
- **Reduction.** a=10000, b=00010, c=00011. Expect x^5 = 00101, then XOR c, giving rsp_data=00110.
- **Round-robin fairness.** All 4 requesters are valid continuously with rsp_ready=1. Expect rsp_id sequence 0,1,2,3,0,1 with one result per cycle.
- **Back-pressure.**
  - Setup: rsp_ready=0 for 3 cycles while requesters 1 and 2 are valid.
  - During the stall: all req_ready=0, and rsp_data/rsp_id are held.
  - On release: results come out in id order 1 then 2.
- **Lock burst.**
  - Setup: requester 2 sends 3 transfers with req_lock=1,1,0 while requesters 0 and 3 are valid.
  - Expected ids: 2,2,2, then 3 then 0.
  - locked=1 from after the first transfer through the third.
- **Reset mid-lock.** Assert reset_n low while LOCKED(1) with rsp_valid=1. Expect rsp_valid=0, locked=0 and ptr=0 immediately, and the next grant goes to the lowest valid index.
